vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
- Internal ÷4 pixel-tick enable (25 MHz) drives horizontal and vertical counters.
- Produces active-low hsync/vsync and drives a solid colour, taken from the 12 slide switches, during the visible region; black elsewhere.
- Sits between the board switches and the VGA connector; top-level display driver for the Pong display path.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch
- HS, 96, horizontal sync width
- HB, 48, horizontal back porch
- VD, 480, vertical display lines
- VF, 10, vertical front porch
- VS, 2, vertical sync width
- VB, 33, vertical back porch
- CLK_DIV, 4, system clocks per pixel

Ports:
- clk  input  1  system clock, 100 MHz, rising edge
- rst  input  1  asynchronous active-low reset
- sw  input  12  colour {R[11:8], G[7:4], B[3:0]} shown in the visible area
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- vga_rgb  output  12  pixel colour {R, G, B}

Behaviour:
- Reset (rst=0, asynchronous): divider=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, vga_rgb=0. All state is held while rst=0.
- Clocking: all state updates on rising clk after reset release.
- Divider: 2-bit counter increments every clk and wraps 3→0.
  - pix_tick=1 when divider==CLK_DIV-1, i.e. one clk in every 4.
- h_cnt (10 bits):
  - On pix_tick, increments.
  - Wraps to 0 after HD+HF+HS+HB-1 = 799.
- v_cnt (10 bits):
  - Increments on pix_tick only when h_cnt==799.
  - Wraps to 0 after VD+VF+VS+VB-1 = 524 (coincident with h_cnt wrap).
- Sync decode (combinational on counters):
  - h_sync_n=0 iff 656 ≤ h_cnt ≤ 751.
  - v_sync_n=0 iff 490 ≤ v_cnt ≤ 491.
- video_on = (h_cnt < 640) && (v_cnt < 480).
- Output registers, updated every clk (not only on tick):
  - hsync ← h_sync_n
  - vsync ← v_sync_n
  - vga_rgb ← video_on ? sw : 12'h000
  - Outputs lag counter state by exactly one clk, so no combinational glitches reach the pins.
- sw is sampled every clk with no synchronizer. A sw change appears on vga_rgb one clk later when video_on=1.
- Timing results:
  - Line = 800 pixels = 3200 clk = 32.0 µs.
  - Frame = 525 lines = 1,680,000 clk = 16.8 ms.
  - hsync low 384 clk per line.
  - vsync low 6400 clk per frame.
- Reset mid-frame: counters and outputs return to reset values immediately. Timing restarts at h_cnt=0, v_cnt=0 on release.
- Non-default parameters: counter widths must hold the H and V totals; the divider counts 0..CLK_DIV-1.

Test Plan:
- Reset: hold rst=0 100 ns with sw=12'h001 → hsync=1, vsync=1, vga_rgb=0 throughout. Release → first pixel tick 4 clks later.
- Active colour: sw=12'h001 after release → vga_rgb=12'h001 for the first 2560 clk of line 0 (1 clk latency), then 12'h000 for the remaining 640 clk.
- hsync timing: measure first hsync falling edge → occurs 656×4(+1) clk after reset release. Low exactly 384 clk, period 3200 clk.
- vsync timing: vsync falls once v_cnt reaches 490 → low exactly 6400 clk, period 1,680,000 clk. vga_rgb=0 for all of lines 480–524.
- Colour change: change sw to 12'hF0A mid-line in the visible area → vga_rgb=12'hF0A on the next clk. The same change during blanking leaves vga_rgb=0.
- Mid-frame reset: assert rst=0 while v_cnt≈300 → outputs go to reset values within the same clk (asynchronously). After release, the next vsync falling edge occurs 490 lines later.

Source files
------------

// File: rtl/vga_sync.sv
// VGA 640x480@60 timing generator: pixel-tick divider, H/V counters, registered sync and colour.
// Latency: hsync/vsync/vga_rgb lag the counter state by one clk; sw reaches vga_rgb one clk after sampling.
// Backpressure: none; free-running raster driven straight to the connector pins.
module vga_sync #(
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HS      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VS      = 2,
    parameter int VB      = 33,
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb
);

    localparam int H_TOT = HD + HF + HS + HB;
    localparam int V_TOT = VD + VF + VS + VB;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_MAX    = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_MAX    = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_DISP   = HW'(HD);
    localparam logic [VW-1:0] V_DISP   = VW'(VD);
    localparam logic [HW-1:0] H_SYNC_B = HW'(HD + HF);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HD + HF + HS - 1);
    localparam logic [VW-1:0] V_SYNC_B = VW'(VD + VF);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VD + VF + VS - 1);

    logic [DW-1:0] div_q,   div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [11:0]   rgb_q,   rgb_d;

    logic pix_tick;
    logic h_sync_n;
    logic v_sync_n;
    logic video_on;

    // Pixel tick, raster counters and the next values of the output registers.
    always_comb begin
        div_d    = div_q;
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        pix_tick = (div_q == DIV_MAX);

        if (pix_tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        // The vertical counter only moves on the tick that ends a line.
        if (pix_tick) begin
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_MAX) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        h_sync_n = !((h_cnt_q >= H_SYNC_B) && (h_cnt_q <= H_SYNC_E));
        v_sync_n = !((v_cnt_q >= V_SYNC_B) && (v_cnt_q <= V_SYNC_E));
        video_on = (h_cnt_q < H_DISP) && (v_cnt_q < V_DISP);

        // Outputs are re-registered every clk so decode glitches never reach the pins.
        hsync_d = h_sync_n;
        vsync_d = v_sync_n;
        rgb_d   = video_on ? sw : 12'h000;
    end

    // State and output registers; reset parks the raster at the top-left with syncs idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 12'h000;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: full-size instance for line timing, shrunken raster for frame timing.
// Edge numbers count rising clk edges after reset release; outputs are sampled 1 ns after each edge.
// Small raster: 24 px/line (sync at 18..20), 13 lines/frame (sync at 8..9), 96 clk/line, 1248 clk/frame.
module tb_vga_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sw  = 12'h000;
    logic        hsync, vsync;
    logic [11:0] vga_rgb;
    logic        hsync_s, vsync_s;
    logic [11:0] vga_rgb_s;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    vga_sync dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .hsync   (hsync),
        .vsync   (vsync),
        .vga_rgb (vga_rgb)
    );

    vga_sync #(
        .HD(16), .HF(2), .HS(3), .HB(3),
        .VD(6),  .VF(2), .VS(2), .VB(3),
        .CLK_DIV(4)
    ) dut_s (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .hsync   (hsync_s),
        .vsync   (vsync_s),
        .vga_rgb (vga_rgb_s)
    );

    task automatic step;
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset;
        sw = 12'h001;
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if ({hsync, vsync, vga_rgb} !== {1'b1, 1'b1, 12'h000}) begin
                fails++;
                $display("FAIL reset_outputs cyc %0d: got hs=%b vs=%b rgb=%h expected hs=1 vs=1 rgb=000",
                         i, hsync, vsync, vga_rgb);
            end
            tests++;
            if ({hsync_s, vsync_s, vga_rgb_s} !== {1'b1, 1'b1, 12'h000}) begin
                fails++;
                $display("FAIL reset_outputs_small cyc %0d: got hs=%b vs=%b rgb=%h expected hs=1 vs=1 rgb=000",
                         i, hsync_s, vsync_s, vga_rgb_s);
            end
        end
        rst = 1'b1;
        edge_n = 0;
        step;
        tests++;
        if (vga_rgb !== 12'h001) begin
            fails++;
            $display("FAIL first_pixel: got %h expected 001", vga_rgb);
        end
    endtask

    task automatic test_active_colour;
        int on_cnt;
        int off_cnt;
        on_cnt  = 0;
        off_cnt = 0;
        do_reset;
        sw = 12'h001;
        for (int i = 0; i < 3200; i++) begin
            step;
            if (edge_n <= 2560 && vga_rgb === 12'h001) on_cnt++;
            if (edge_n > 2560 && vga_rgb === 12'h000) off_cnt++;
        end
        tests++;
        if (on_cnt !== 2560) begin
            fails++;
            $display("FAIL active_clocks: got %0d expected 2560", on_cnt);
        end
        tests++;
        if (off_cnt !== 640) begin
            fails++;
            $display("FAIL blank_clocks: got %0d expected 640", off_cnt);
        end
        step;
        tests++;
        if (vga_rgb !== 12'h001) begin
            fails++;
            $display("FAIL line1_start: got %h expected 001", vga_rgb);
        end
    endtask

    task automatic test_hsync;
        logic prev;
        int   fall1, rise1, fall2, low_cnt, vlow;
        prev = 1'b1; fall1 = -1; rise1 = -1; fall2 = -1; low_cnt = 0; vlow = 0;
        do_reset;
        for (int i = 0; i < 6400; i++) begin
            step;
            if (prev === 1'b1 && hsync === 1'b0) begin
                if (fall1 < 0) fall1 = edge_n;
                else if (fall2 < 0) fall2 = edge_n;
            end
            if (prev === 1'b0 && hsync === 1'b1 && rise1 < 0) rise1 = edge_n;
            if (edge_n <= 3200 && hsync === 1'b0) low_cnt++;
            if (vsync !== 1'b1) vlow++;
            prev = hsync;
        end
        tests++;
        if (fall1 !== 2625) begin
            fails++;
            $display("FAIL hsync_first_fall: got edge %0d expected 2625", fall1);
        end
        tests++;
        if (rise1 !== 3009) begin
            fails++;
            $display("FAIL hsync_first_rise: got edge %0d expected 3009", rise1);
        end
        tests++;
        if (low_cnt !== 384) begin
            fails++;
            $display("FAIL hsync_low_clocks: got %0d expected 384", low_cnt);
        end
        tests++;
        if (fall2 - fall1 !== 3200) begin
            fails++;
            $display("FAIL hsync_period: got %0d expected 3200", fall2 - fall1);
        end
        tests++;
        if (vlow !== 0) begin
            fails++;
            $display("FAIL vsync_idle_lines01: got %0d low clocks expected 0", vlow);
        end
    endtask

    task automatic test_colour_change;
        do_reset;
        sw = 12'h001;
        repeat (1000) step;
        tests++;
        if (vga_rgb !== 12'h001) begin
            fails++;
            $display("FAIL colour_before_change: got %h expected 001", vga_rgb);
        end
        sw = 12'hF0A;
        step;
        tests++;
        if (vga_rgb !== 12'hF0A) begin
            fails++;
            $display("FAIL colour_change_visible: got %h expected f0a", vga_rgb);
        end
        while (edge_n < 2800) step;
        sw = 12'h123;
        step;
        tests++;
        if (vga_rgb !== 12'h000) begin
            fails++;
            $display("FAIL colour_change_blanking: got %h expected 000", vga_rgb);
        end
    endtask

    task automatic test_vsync;
        logic prev_v, prev_h;
        int   fall1, rise1, fall2, low_cnt, vbad, hfall;
        prev_v = 1'b1; prev_h = 1'b1;
        fall1 = -1; rise1 = -1; fall2 = -1; low_cnt = 0; vbad = 0; hfall = -1;
        do_reset;
        sw = 12'h001;
        for (int i = 0; i < 2100; i++) begin
            step;
            if (prev_v === 1'b1 && vsync_s === 1'b0) begin
                if (fall1 < 0) fall1 = edge_n;
                else if (fall2 < 0) fall2 = edge_n;
            end
            if (prev_v === 1'b0 && vsync_s === 1'b1 && rise1 < 0) rise1 = edge_n;
            if (edge_n <= 1248 && vsync_s === 1'b0) low_cnt++;
            if (edge_n >= 577 && edge_n <= 1248 && vga_rgb_s !== 12'h000) vbad++;
            if (prev_h === 1'b1 && hsync_s === 1'b0 && hfall < 0) hfall = edge_n;
            prev_v = vsync_s;
            prev_h = hsync_s;
        end
        tests++;
        if (hfall !== 73) begin
            fails++;
            $display("FAIL small_hsync_fall: got edge %0d expected 73", hfall);
        end
        tests++;
        if (fall1 !== 769) begin
            fails++;
            $display("FAIL vsync_first_fall: got edge %0d expected 769", fall1);
        end
        tests++;
        if (rise1 !== 961) begin
            fails++;
            $display("FAIL vsync_first_rise: got edge %0d expected 961", rise1);
        end
        tests++;
        if (low_cnt !== 192) begin
            fails++;
            $display("FAIL vsync_low_clocks: got %0d expected 192", low_cnt);
        end
        tests++;
        if (fall2 - fall1 !== 1248) begin
            fails++;
            $display("FAIL vsync_period: got %0d expected 1248", fall2 - fall1);
        end
        tests++;
        if (vbad !== 0) begin
            fails++;
            $display("FAIL vblank_black: got %0d coloured clocks expected 0", vbad);
        end
    endtask

    task automatic test_mid_frame_reset;
        logic prev_v;
        int   fall1;
        prev_v = 1'b1;
        fall1  = -1;
        do_reset;
        sw = 12'h001;
        repeat (400) step;
        tests++;
        if ({vga_rgb, vga_rgb_s} !== {12'h001, 12'h001}) begin
            fails++;
            $display("FAIL pre_reset_colour: got %h/%h expected 001/001", vga_rgb, vga_rgb_s);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({hsync, vsync, vga_rgb} !== {1'b1, 1'b1, 12'h000}) begin
            fails++;
            $display("FAIL async_reset: got hs=%b vs=%b rgb=%h expected hs=1 vs=1 rgb=000",
                     hsync, vsync, vga_rgb);
        end
        tests++;
        if ({hsync_s, vsync_s, vga_rgb_s} !== {1'b1, 1'b1, 12'h000}) begin
            fails++;
            $display("FAIL async_reset_small: got hs=%b vs=%b rgb=%h expected hs=1 vs=1 rgb=000",
                     hsync_s, vsync_s, vga_rgb_s);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (vga_rgb_s !== 12'h000) begin
            fails++;
            $display("FAIL reset_hold: got %h expected 000", vga_rgb_s);
        end
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 1000; i++) begin
            step;
            if (prev_v === 1'b1 && vsync_s === 1'b0 && fall1 < 0) fall1 = edge_n;
            prev_v = vsync_s;
        end
        tests++;
        if (fall1 !== 769) begin
            fails++;
            $display("FAIL vsync_after_mid_reset: got edge %0d expected 769", fall1);
        end
    endtask

    initial begin
        test_reset;
        test_active_colour;
        test_hsync;
        test_colour_change;
        test_vsync;
        test_mid_frame_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
